// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit (MUL, SMUL, UMUL, DIV) with a start/busy/done handshake.
// One shift-add or shift-subtract step per cycle; results and flags are registered on entry to DONE.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SMUL = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2:0]         op_reg, op_next;
  logic               neg_reg, neg_next;
  logic [WIDTH-1:0]   hi_reg, hi_next, lo_reg, lo_next, m_reg, m_next;
  logic [WIDTH-1:0]   res_lo_reg, res_lo_next, res_hi_reg, res_hi_next;
  logic               flag_n_reg, flag_n_next, flag_z_reg, flag_z_next;
  logic               dz_reg, dz_next, busy_reg, busy_next, done_reg, done_next;

  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    neg_next    = neg_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    m_next      = m_reg;
    res_lo_next = res_lo_reg;
    res_hi_next = res_hi_reg;
    flag_n_next = flag_n_reg;
    flag_z_next = flag_z_reg;
    dz_next     = dz_reg;

    // Multiply: hi accumulates, lo holds the multiplier and shifts out its LSB each step.
    mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : '0);
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    div_sh   = {hi_reg, lo_reg[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_reg};

    if (op_reg == OP_DIV) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end

    prod = {step_hi, step_lo};
    if (op_reg == OP_SMUL && neg_reg)
      prod = -prod;

    case (state_reg)
      IDLE: begin
        if (start && op[2]) begin
          op_next  = op;
          cnt_next = '0;
          neg_next = a[WIDTH-1] ^ b[WIDTH-1];
          hi_next  = '0;
          if (op == OP_SMUL) begin
            lo_next = a[WIDTH-1] ? -a : a;
            m_next  = b[WIDTH-1] ? -b : b;
          end else begin
            lo_next = a;
            m_next  = b;
          end
          if (op == OP_DIV && b == '0) begin
            state_next  = DONE;
            res_lo_next = '0;
            res_hi_next = a;
            flag_n_next = 1'b0;
            flag_z_next = 1'b1;
            dz_next     = 1'b1;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        hi_next  = step_hi;
        lo_next  = step_lo;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          state_next  = DONE;
          res_hi_next = prod[2*WIDTH-1:WIDTH];
          res_lo_next = prod[WIDTH-1:0];
          dz_next     = 1'b0;
          if (op_reg == OP_MUL || op_reg == OP_DIV) begin
            flag_n_next = prod[WIDTH-1];
            flag_z_next = (prod[WIDTH-1:0] == '0);
          end else begin
            flag_n_next = prod[2*WIDTH-1];
            flag_z_next = (prod == '0);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == CALC);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      m_reg      <= '0;
      res_lo_reg <= '0;
      res_hi_reg <= '0;
      flag_n_reg <= 1'b0;
      flag_z_reg <= 1'b0;
      dz_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      neg_reg    <= neg_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      m_reg      <= m_next;
      res_lo_reg <= res_lo_next;
      res_hi_reg <= res_hi_next;
      flag_n_reg <= flag_n_next;
      flag_z_reg <= flag_z_next;
      dz_reg     <= dz_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign result_lo = res_lo_reg;
  assign result_hi = res_hi_reg;
  assign flag_n    = flag_n_reg;
  assign flag_z    = flag_z_reg;
  assign dz        = dz_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: an 8-bit and a 32-bit instance share clock and reset.
module tb_muldiv_seq;

  logic clk;
  logic rst_n;

  logic       s8, busy8, done8, n8, z8, dz8;
  logic [2:0] op8;
  logic [7:0] a8, b8, lo8, hi8;

  logic        s32, busy32, done32, n32, z32, dz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, lo32, hi32;

  int checks = 0;
  int errors = 0;
  int lat, bc, dcnt;

  muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(s8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8),
    .flag_n(n8), .flag_z(z8), .dz(dz8)
  );

  muldiv_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst_n), .start(s32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result_lo(lo32), .result_hi(hi32),
    .flag_n(n32), .flag_z(z32), .dz(dz32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one 8-bit op; returns with the bench in the done cycle (or at timeout).
  task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int l, output int nb);
    s8 = 1'b1; op8 = o; a8 = x; b8 = y;
    tick();
    s8 = 1'b0;
    l = 1; nb = 0;
    while (!done8 && l < 100) begin
      if (busy8) nb++;
      tick();
      l++;
    end
    $display("W8  op=%b a=%h b=%h -> hi=%h lo=%h n=%b z=%b dz=%b lat=%0d",
             o, x, y, hi8, lo8, n8, z8, dz8, l);
  endtask

  task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int l, output int nb);
    s32 = 1'b1; op32 = o; a32 = x; b32 = y;
    tick();
    s32 = 1'b0;
    l = 1; nb = 0;
    while (!done32 && l < 100) begin
      if (busy32) nb++;
      tick();
      l++;
    end
    $display("W32 op=%b a=%h b=%h -> hi=%h lo=%h n=%b z=%b dz=%b lat=%0d",
             o, x, y, hi32, lo32, n32, z32, dz32, l);
  endtask

  initial begin
    rst_n = 1'b0;
    s8 = 1'b1; op8 = 3'b100; a8 = 8'h12; b8 = 8'h34;
    s32 = 1'b1; op32 = 3'b100; a32 = 32'd1; b32 = 32'd2;
    #1;
    tick(); tick();
    chk("rst busy8", busy8, 0);
    chk("rst done8", done8, 0);
    chk("rst res8", {hi8, lo8}, 0);
    chk("rst flags8", {n8, z8, dz8}, 0);
    chk("rst res32", {hi32, lo32}, 0);
    chk("rst ctl32", {busy32, done32, n32, z32, dz32}, 0);
    s8 = 1'b0; s32 = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("idle busy8", {busy8, done8}, 0);
    $display("reset: busy8=%b done8=%b busy32=%b", busy8, done8, busy32);

    // UMUL 0xFF*0xFF
    issue8(3'b110, 8'hFF, 8'hFF, lat, bc);
    chk("umul lat", lat, 9);
    chk("umul busy cycles", bc, 8);
    chk("umul busy in done", busy8, 0);
    chk("umul res", {hi8, lo8}, 16'hFE01);
    chk("umul flags", {n8, z8, dz8}, 3'b100);
    tick();
    chk("umul done pulse", done8, 0);

    // SMUL most-negative squared
    issue8(3'b101, 8'h80, 8'h80, lat, bc);
    chk("smul80 res", {hi8, lo8}, 16'h4000);
    chk("smul80 flags", {n8, z8, dz8}, 3'b000);
    tick();

    // SMUL -3*5
    issue8(3'b101, 8'hFD, 8'h05, lat, bc);
    chk("smul-3 res", {hi8, lo8}, 16'hFFF1);
    chk("smul-3 flags", {n8, z8, dz8}, 3'b100);
    tick();

    // MUL exposes full product; flags come from lo only
    issue8(3'b100, 8'h10, 8'h20, lat, bc);
    chk("mul hi/lo", {hi8, lo8}, 16'h0200);
    chk("mul flags", {n8, z8, dz8}, 3'b010);
    tick();

    // MUL zero
    issue8(3'b100, 8'h00, 8'h09, lat, bc);
    chk("mul0 res", {hi8, lo8}, 16'h0000);
    chk("mul0 flags", {n8, z8, dz8}, 3'b010);
    tick();

    // DIV 100/7, 32-bit
    issue32(3'b111, 32'd100, 32'd7, lat, bc);
    chk("div lat", lat, 33);
    chk("div busy cycles", bc, 32);
    chk("div lo", lo32, 14);
    chk("div hi", hi32, 2);
    chk("div flags", {n32, z32, dz32}, 3'b000);
    tick();

    // DIV by zero, 32-bit
    issue32(3'b111, 32'd5, 32'd0, lat, bc);
    chk("dz lat", lat, 1);
    chk("dz busy", {bc[0], busy32}, 0);
    chk("dz res", {hi32, lo32}, {32'd5, 32'd0});
    chk("dz flags", {n32, z32, dz32}, 3'b011);
    tick();
    chk("dz done pulse", done32, 0);

    // start held through CALC with changing operands: one done, original operands
    s8 = 1'b1; op8 = 3'b110; a8 = 8'h0C; b8 = 8'h0A;
    tick();
    lat = 1;
    while (!done8 && lat < 100) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
      lat++;
    end
    s8 = 1'b0;
    $display("W8  hold-start umul 0C*0A -> hi=%h lo=%h lat=%0d", hi8, lo8, lat);
    chk("hold lat", lat, 9);
    chk("hold res", {hi8, lo8}, 16'h0078);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) dcnt++;
    end
    chk("hold single done", dcnt, 0);

    // op[2]=0 is never accepted; results hold
    s8 = 1'b1; op8 = 3'b011; a8 = 8'h33; b8 = 8'h44;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) dcnt++;
    end
    s8 = 1'b0;
    $display("W8  op=011 held 12 cycles -> activity=%0d", dcnt);
    chk("bad op ignored", dcnt, 0);
    chk("results hold", {hi8, lo8}, 16'h0078);

    // Reset mid-operation
    s8 = 1'b1; op8 = 3'b110; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    s8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst ctl", {busy8, done8, n8, z8, dz8}, 0);
    chk("midrst res", {hi8, lo8}, 0);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) dcnt++;
    end
    $display("W8  reset mid-umul -> activity=%0d hi=%h lo=%h", dcnt, hi8, lo8);
    chk("midrst no done", dcnt, 0);

    issue8(3'b110, 8'd3, 8'd4, lat, bc);
    chk("post-rst lat", lat, 9);
    chk("post-rst res", {hi8, lo8}, 16'h000C);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative, parametrised multiply/divide unit for the multicycle datapath. It executes the four multiply-class ALUControl codes: MUL, SMUL, UMUL and DIV. It uses a radix-2 shift-add/shift-subtract engine with a start/busy/done handshake, so the main FSM can hold in a wait state until the result is ready. It replaces single-cycle combinational multiply/divide in the ALU and supports any operand width.

## Interface
- WIDTH, 32, operand width in bits (≥4; benches also run 8).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  in  1  request; accepted only in IDLE with op[2]=1.
- op  in  3  100 MUL, 101 SMUL, 110 UMUL, 111 DIV; op[2]=0 never accepted.
- a  in  WIDTH  first operand / dividend; sampled on acceptance only.
- b  in  WIDTH  second operand / divisor; sampled on acceptance only.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse; result_lo/result_hi/flags valid in this cycle.
- result_lo  out  WIDTH  low product word, or quotient.
- result_hi  out  WIDTH  high product word, or remainder.
- flag_n  out  1  negative flag of the result.
- flag_z  out  1  zero flag of the result.
- dz  out  1  divide-by-zero indicator; valid with done.

## Operation
- States:
  - IDLE: wait for a request.
  - CALC: WIDTH iterations.
  - DONE: one cycle, then return to IDLE.
- Transitions:
  - IDLE→CALC on accepted start.
  - IDLE→DONE on accepted DIV with b=0.
  - CALC→DONE when the iteration counter reaches WIDTH-1.
  - DONE→IDLE unconditionally.
- start in CALC or DONE is ignored and not queued.
- MUL, UMUL: unsigned 2·WIDTH product.
  - {result_hi,result_lo} = a·b.
  - MUL exposes the full product; the datapath writes result_lo only.
- SMUL: two's-complement operands.
  - Magnitudes are latched at acceptance and multiplied unsigned.
  - The 2·WIDTH result is negated in DONE when a[WIDTH-1]^b[WIDTH-1].
  - The most negative operand is handled (e.g. WIDTH=8: −128·−128 = 0x4000).
- DIV: unsigned restoring division.
  - result_lo = a / b; result_hi = a % b.
- DIV with b=0:
  - No iteration.
  - result_lo=0, result_hi=a, dz=1.
- Flags are registered with the result:
  - MUL, DIV: flag_n = result_lo[WIDTH-1]; flag_z = (result_lo==0).
  - SMUL, UMUL: flag_n = result_hi[WIDTH-1]; flag_z = ({hi,lo}==0).
- dz=0 for every case other than DIV with b=0.
- Iteration counter: ceil(log2(WIDTH)) bits, cleared on acceptance.
- Operand, accumulator and op registers are internal. Inputs may change freely after acceptance.

## Timing
- Reset (reset=0 at a rising edge):
  - State becomes IDLE; counter cleared.
  - busy=0, done=0, dz=0, flag_n=0, flag_z=0, result_lo=0, result_hi=0.
  - Reset during CALC or DONE aborts the operation; no done is produced.
- Acceptance at edge T (IDLE, start=1, op[2]=1, reset=1):
  - busy=1 from T+1 through T+WIDTH.
  - done=1 in cycle T+WIDTH+1 only.
- Divide-by-zero accepted at T: done=1 in cycle T+1, busy never asserted.
- Next acceptance is possible at the edge ending the cycle after done (minimum issue interval WIDTH+2 cycles).
- Results hold after DONE until the next accepted operation's DONE (or reset). They are not cleared by acceptance.
- done and busy are never high together.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, WIDTH=8:
  - Hold reset=0 for 2 cycles with start=1, op=100 → all outputs 0.
  - Release with start=0 → stays IDLE, busy=0.
- UMUL, WIDTH=8: a=0xFF, b=0xFF, start at T → busy T+1..T+8; done at T+9; hi=0xFE, lo=0x01, flag_n=1, flag_z=0.
- SMUL, WIDTH=8:
  - a=0x80, b=0x80 → {hi,lo}=0x4000, flag_n=0.
  - a=0xFD (−3), b=0x05 → {hi,lo}=0xFFF1, flag_n=1.
- DIV, WIDTH=32:
  - a=100, b=7 → lo=14, hi=2, dz=0, done 33 cycles after acceptance.
  - a=5, b=0 → done next cycle; lo=0, hi=5, dz=1.
- Handshake, WIDTH=8:
  - start held high through CALC with changing a/b → single done, results from originally sampled operands.
  - op=011 with start → never accepted.
  - MUL with a=0, b=9 → flag_z=1.
- Reset mid-operation, WIDTH=8: reset=0 at T+4 of a UMUL → no done pulse; outputs 0; a fresh UMUL 3×4 then yields lo=12, hi=0.
